// File: rtl/watermelon_flight_ctrl_if.sv
// Interface bundling the sprite sequencer's control inputs and anchor outputs.
//   frame_tick, start, start_x, slice_req : from frame timing / slash detection
//   leftX_watermelon, topY_watermelon     : sprite anchor to the renderers
//   sliced, visible                       : renderer select / blanking
//   busy, score_pulse, miss_pulse         : status and game-logic events
// slave  modport: the flight controller.
// master modport: whatever drives the requests and consumes the outputs.
interface watermelon_flight_ctrl_if;
    logic       frame_tick;
    logic       start;
    logic [6:0] start_x;
    logic       slice_req;
    logic [6:0] leftX_watermelon;
    logic [5:0] topY_watermelon;
    logic       sliced;
    logic       visible;
    logic       busy;
    logic       score_pulse;
    logic       miss_pulse;

    modport slave (
        input  frame_tick, start, start_x, slice_req,
        output leftX_watermelon, topY_watermelon, sliced, visible,
               busy, score_pulse, miss_pulse
    );

    modport master (
        output frame_tick, start, start_x, slice_req,
        input  leftX_watermelon, topY_watermelon, sliced, visible,
               busy, score_pulse, miss_pulse
    );
endinterface

// File: rtl/watermelon_flight_ctrl.sv
// Frame-rate flight sequencer for one watermelon sprite on a 96x64 OLED.
// Launches the sprite from the bottom edge, rises to the apex, holds, falls,
// and despawns; a slash hit diverts it into a faster sliced fall. Emits a
// one-cycle score_pulse (sliced despawn) or miss_pulse (unsliced despawn).
// Ports:
//   CLOCK : system clock
//   RESET : synchronous, active-high reset
//   bus   : watermelon_flight_ctrl_if.slave (requests in, anchor/status out)
// All outputs are registered.
// Optional feature macro: WMELON_AUTO_RELAUNCH_EN -- when defined, IDLE
// counts frame_ticks after each despawn and relaunches after RELAUNCH_GAP.
module watermelon_flight_ctrl #(
    parameter int RISE_STEP    = 2,
    parameter int FALL_STEP    = 2,
    parameter int SLICE_STEP   = 3,
    parameter int APEX_Y       = 3,
    parameter int BOTTOM_Y     = 63,
    parameter int APEX_HOLD    = 8,
    parameter int X_STEP       = 1,
    parameter int X_MAX        = 40,
    parameter int RELAUNCH_GAP = 16
) (
    input logic                    CLOCK,
    input logic                    RESET,
    watermelon_flight_ctrl_if.slave bus
);
    localparam int HOLD_W = $clog2(APEX_HOLD + 1);

    typedef enum logic [2:0] {S_IDLE, S_RISE, S_HOLD, S_FALL, S_SLICED} state_e;

    state_e              state_q, state_d;
    logic [6:0]          leftx_q, leftx_d;
    logic [5:0]          topy_q, topy_d;
    logic                sliced_q, sliced_d;
    logic                visible_q, visible_d;
    logic                busy_q, busy_d;
    logic                score_q, score_d;
    logic                miss_q, miss_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;

`ifdef WMELON_AUTO_RELAUNCH_EN
    localparam int GAP_W = $clog2(RELAUNCH_GAP + 1);
    logic [GAP_W-1:0]    gap_q, gap_d;
    // armed only after a despawn, so the first launch after reset needs start
    logic                armed_q, armed_d;
    logic                auto_go;
    assign auto_go = armed_q && bus.frame_tick && (gap_q == GAP_W'(RELAUNCH_GAP - 1));
`endif

    logic                launch;
    logic [6:0]          x_sum, x_next, x_launch;
    logic signed [6:0]   y_sub;
    logic [6:0]          y_fsum, y_ssum;
    logic [5:0]          y_rise, y_fall, y_slc;
    logic                in_flight, slice_go, cut_move;

    // leftX never exceeds X_MAX, so the 7-bit sum cannot wrap
    assign x_sum    = leftx_q + 7'(X_STEP);
    assign x_next   = (x_sum > 7'(X_MAX)) ? 7'(X_MAX) : x_sum;
    assign x_launch = (bus.start_x > 7'(X_MAX)) ? 7'(X_MAX) : bus.start_x;

    // rise is evaluated signed so an overshoot below zero still clamps to apex
    assign y_sub  = $signed({1'b0, topy_q} - 7'(RISE_STEP));
    assign y_rise = (y_sub < $signed(7'(APEX_Y))) ? 6'(APEX_Y) : y_sub[5:0];
    assign y_fsum = {1'b0, topy_q} + 7'(FALL_STEP);
    assign y_fall = (y_fsum > 7'(BOTTOM_Y)) ? 6'(BOTTOM_Y) : y_fsum[5:0];
    assign y_ssum = {1'b0, topy_q} + 7'(SLICE_STEP);
    assign y_slc  = (y_ssum > 7'(BOTTOM_Y)) ? 6'(BOTTOM_Y) : y_ssum[5:0];

    assign in_flight = (state_q == S_RISE) || (state_q == S_HOLD) || (state_q == S_FALL);
    assign slice_go  = in_flight && bus.slice_req;
    // a tick coinciding with the slash already uses the sliced trajectory
    assign cut_move  = bus.frame_tick && (slice_go || (state_q == S_SLICED));

`ifdef WMELON_AUTO_RELAUNCH_EN
    assign launch = bus.start || auto_go;
`else
    assign launch = bus.start;
`endif

    always_comb begin
        state_d   = state_q;
        leftx_d   = leftx_q;
        topy_d    = topy_q;
        sliced_d  = sliced_q;
        visible_d = visible_q;
        hold_d    = hold_q;
        score_d   = 1'b0;
        miss_d    = 1'b0;
`ifdef WMELON_AUTO_RELAUNCH_EN
        gap_d     = gap_q;
        armed_d   = armed_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (launch) begin
                    leftx_d   = x_launch;
                    topy_d    = 6'(BOTTOM_Y);
                    sliced_d  = 1'b0;
                    visible_d = 1'b1;
                    state_d   = S_RISE;
`ifdef WMELON_AUTO_RELAUNCH_EN
                    gap_d     = '0;
                    armed_d   = 1'b0;
                end else if (armed_q && bus.frame_tick) begin
                    gap_d     = gap_q + GAP_W'(1);
`endif
                end
            end
            S_RISE: begin
                if (!slice_go && bus.frame_tick) begin
                    topy_d  = y_rise;
                    leftx_d = x_next;
                    if (y_rise == 6'(APEX_Y)) begin
                        hold_d  = HOLD_W'(APEX_HOLD);
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!slice_go && bus.frame_tick) begin
                    hold_d = hold_q - HOLD_W'(1);
                    if (hold_q == HOLD_W'(1)) state_d = S_FALL;
                end
            end
            S_FALL: begin
                if (!slice_go && bus.frame_tick) begin
                    topy_d  = y_fall;
                    leftx_d = x_next;
                    if (y_fall == 6'(BOTTOM_Y)) begin
                        miss_d    = 1'b1;
                        visible_d = 1'b0;
                        state_d   = S_IDLE;
                    end
                end
            end
            default: ;
        endcase

        if (slice_go) begin
            state_d  = S_SLICED;
            sliced_d = 1'b1;
        end

        if (cut_move) begin
            topy_d  = y_slc;
            leftx_d = x_next;
            if (y_slc == 6'(BOTTOM_Y)) begin
                score_d   = 1'b1;
                visible_d = 1'b0;
                sliced_d  = 1'b0;
                state_d   = S_IDLE;
            end
        end

`ifdef WMELON_AUTO_RELAUNCH_EN
        if (score_d || miss_d) begin
            armed_d = 1'b1;
            gap_d   = '0;
        end
`endif

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            leftx_q   <= '0;
            topy_q    <= 6'(BOTTOM_Y);
            sliced_q  <= 1'b0;
            visible_q <= 1'b0;
            busy_q    <= 1'b0;
            score_q   <= 1'b0;
            miss_q    <= 1'b0;
            hold_q    <= '0;
`ifdef WMELON_AUTO_RELAUNCH_EN
            gap_q     <= '0;
            armed_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            leftx_q   <= leftx_d;
            topy_q    <= topy_d;
            sliced_q  <= sliced_d;
            visible_q <= visible_d;
            busy_q    <= busy_d;
            score_q   <= score_d;
            miss_q    <= miss_d;
            hold_q    <= hold_d;
`ifdef WMELON_AUTO_RELAUNCH_EN
            gap_q     <= gap_d;
            armed_q   <= armed_d;
`endif
        end
    end

    assign bus.leftX_watermelon = leftx_q;
    assign bus.topY_watermelon  = topy_q;
    assign bus.sliced           = sliced_q;
    assign bus.visible          = visible_q;
    assign bus.busy             = busy_q;
    assign bus.score_pulse      = score_q;
    assign bus.miss_pulse       = miss_q;
endmodule

// File: tb/tb_watermelon_flight_ctrl.sv
// Directed bench for watermelon_flight_ctrl. A behavioural flight model
// predicts every registered output each cycle; predictions are queued when
// the stimulus is driven and compared after the following clock edge.
module tb_watermelon_flight_ctrl;
    localparam int ST_IDLE = 0, ST_RISE = 1, ST_HOLD = 2, ST_FALL = 3, ST_SLICED = 4;

    typedef struct packed {
        logic [6:0] x;
        logic [5:0] y;
        logic       sl;
        logic       vis;
        logic       busy;
        logic       score;
        logic       miss;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    watermelon_flight_ctrl_if bus_if ();

    watermelon_flight_ctrl dut (
        .CLOCK (clk),
        .RESET (rst),
        .bus   (bus_if)
    );

    obs_t q[$];
    int   vectors    = 0;
    int   miscompares = 0;

    // model state
    int m_state = ST_IDLE, m_x = 0, m_y = 63, m_sl = 0, m_vis = 0, m_hold = 0;
    int m_gap = 0, m_armed = 0;

    task automatic m_launch(input logic [6:0] sx);
        m_x     = (int'(sx) < 40) ? int'(sx) : 40;
        m_y     = 63;
        m_sl    = 0;
        m_vis   = 1;
        m_state = ST_RISE;
        m_gap   = 0;
        m_armed = 0;
    endtask

    task automatic model_step(input bit r, input bit ft, input bit st,
                              input logic [6:0] sx, input bit sr, output obs_t e);
        bit sc = 0, ms = 0;
        if (r) begin
            m_state = ST_IDLE; m_x = 0; m_y = 63; m_sl = 0; m_vis = 0;
            m_hold = 0; m_gap = 0; m_armed = 0;
        end else if (m_state == ST_IDLE) begin
            if (st) m_launch(sx);
`ifdef WMELON_AUTO_RELAUNCH_EN
            else if (m_armed != 0 && ft) begin
                m_gap++;
                if (m_gap == 16) m_launch(sx);
            end
`endif
        end else begin
            if (sr && m_state != ST_SLICED) begin
                m_state = ST_SLICED;
                m_sl    = 1;
            end
            if (ft) begin
                case (m_state)
                    ST_RISE: begin
                        m_y = (m_y - 2 < 3) ? 3 : m_y - 2;
                        m_x = (m_x + 1 > 40) ? 40 : m_x + 1;
                        if (m_y == 3) begin m_hold = 8; m_state = ST_HOLD; end
                    end
                    ST_HOLD: begin
                        m_hold--;
                        if (m_hold == 0) m_state = ST_FALL;
                    end
                    ST_FALL: begin
                        m_y = (m_y + 2 > 63) ? 63 : m_y + 2;
                        m_x = (m_x + 1 > 40) ? 40 : m_x + 1;
                        if (m_y == 63) begin ms = 1; m_vis = 0; m_state = ST_IDLE; end
                    end
                    default: begin
                        m_y = (m_y + 3 > 63) ? 63 : m_y + 3;
                        m_x = (m_x + 1 > 40) ? 40 : m_x + 1;
                        if (m_y == 63) begin sc = 1; m_vis = 0; m_sl = 0; m_state = ST_IDLE; end
                    end
                endcase
                if (sc || ms) begin m_armed = 1; m_gap = 0; end
            end
        end
        e.x     = 7'(m_x);
        e.y     = 6'(m_y);
        e.sl    = (m_sl != 0);
        e.vis   = (m_vis != 0);
        e.busy  = (m_state != ST_IDLE);
        e.score = sc;
        e.miss  = ms;
    endtask

    // One clock: drive inputs, queue prediction, compare after the edge.
    task automatic cyc(input string tag, input bit r, input bit ft, input bit st,
                       input logic [6:0] sx, input bit sr);
        obs_t e, got;
        rst               = r;
        bus_if.frame_tick = ft;
        bus_if.start      = st;
        bus_if.start_x    = sx;
        bus_if.slice_req  = sr;
        model_step(r, ft, st, sx, sr, e);
        q.push_back(e);
        @(posedge clk);
        #1;
        got = '{x: bus_if.leftX_watermelon, y: bus_if.topY_watermelon,
                sl: bus_if.sliced, vis: bus_if.visible, busy: bus_if.busy,
                score: bus_if.score_pulse, miss: bus_if.miss_pulse};
        e = q.pop_front();
        vectors++;
        assert (got === e) else begin
            miscompares++;
            $error("FAIL %s: got x=%0d y=%0d sl=%b vis=%b busy=%b sc=%b ms=%b, exp x=%0d y=%0d sl=%b vis=%b busy=%b sc=%b ms=%b",
                   tag, got.x, got.y, got.sl, got.vis, got.busy, got.score, got.miss,
                   e.x, e.y, e.sl, e.vis, e.busy, e.score, e.miss);
        end
    endtask

    // Alternate tick / no-tick cycles until the model reaches the target
    // state (and topY if ty >= 0), within a cycle budget.
    task automatic run_to(input string tag, input int ts, input int ty, input int budget);
        int n = 0;
        while (!(m_state == ts && (ty < 0 || m_y == ty)) && n < budget) begin
            cyc(tag, 1'b0, n[0] == 1'b0, 1'b0, 7'd0, 1'b0);
            n++;
        end
        if (!(m_state == ts && (ty < 0 || m_y == ty))) begin
            miscompares++;
            $display("FAIL %s: budget of %0d cycles expired, want state %0d", tag, budget, ts);
        end
    endtask

    initial begin
        bus_if.frame_tick = 1'b0;
        bus_if.start      = 1'b0;
        bus_if.start_x    = 7'd0;
        bus_if.slice_req  = 1'b0;

        cyc("reset0", 1'b1, 1'b0, 1'b0, 7'd0, 1'b0);
        cyc("reset1", 1'b1, 1'b1, 1'b1, 7'd5, 1'b1);

        // slice_req in IDLE must change nothing
        for (int i = 0; i < 3; i++) cyc("idle_slice", 1'b0, 1'b1, 1'b0, 7'd0, 1'b1);

        // full unsliced flight from x=10, with a stray start during RISE
        cyc("launch10", 1'b0, 1'b0, 1'b1, 7'd10, 1'b0);
        for (int i = 0; i < 4; i++) cyc("rise", 1'b0, i[0] == 1'b0, 1'b0, 7'd0, 1'b0);
        cyc("start_in_rise", 1'b0, 1'b0, 1'b1, 7'd90, 1'b0);
        cyc("start_tick_rise", 1'b0, 1'b1, 1'b1, 7'd0, 1'b0);
        run_to("flight_miss", ST_IDLE, -1, 400);
        for (int i = 0; i < 2; i++) cyc("after_miss", 1'b0, 1'b0, 1'b0, 7'd0, 1'b0);

        // start_x clamp, slice after 5 ticks
        run_to("to_idle_a", ST_IDLE, -1, 400);
        cyc("launch90", 1'b0, 1'b0, 1'b1, 7'd90, 1'b0);
        for (int i = 0; i < 5; i++) cyc("rise5", 1'b0, 1'b1, 1'b0, 7'd0, 1'b0);
        cyc("slice", 1'b0, 1'b0, 1'b0, 7'd0, 1'b1);
        cyc("slice_hold", 1'b0, 1'b0, 1'b0, 7'd0, 1'b1);
        run_to("sliced_score", ST_IDLE, -1, 100);
        cyc("after_score", 1'b0, 1'b0, 1'b0, 7'd0, 1'b0);

        // slice and tick together at the apex
        run_to("to_idle_b", ST_IDLE, -1, 400);
        cyc("launch20", 1'b0, 1'b0, 1'b1, 7'd20, 1'b0);
        run_to("to_hold", ST_HOLD, -1, 200);
        cyc("hold_slice_tick", 1'b0, 1'b1, 1'b0, 7'd0, 1'b1);
        run_to("hold_sliced_out", ST_IDLE, -1, 100);

        // 100 idle ticks after a despawn: relaunch only with the macro
        for (int i = 0; i < 100; i++) cyc("idle_ticks", 1'b0, 1'b1, 1'b0, 7'd25, 1'b0);

        // reset mid-fall at topY=31
        run_to("to_idle_c", ST_IDLE, -1, 400);
        cyc("launch5", 1'b0, 1'b0, 1'b1, 7'd5, 1'b0);
        run_to("to_fall31", ST_FALL, 31, 400);
        cyc("reset_mid", 1'b1, 1'b0, 1'b0, 7'd0, 1'b0);
        for (int i = 0; i < 3; i++) cyc("post_reset", 1'b0, 1'b1, 1'b0, 7'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/watermelon_flight_ctrl.md
Name: watermelon_flight_ctrl

Overview:
- Frame-rate sequencer for one watermelon sprite on the 96x64 OLED.
- Owns the sprite's leftX/topY position and the whole/sliced select.
- Runs launch, rise, apex hold, fall, slice and despawn. Emits score/miss pulses to game logic.
- Sits between the frame timing/slash-detect logic and the whole/sliced watermelon pixel renderers, whose anchor inputs it drives.

Parameters:
- RISE_STEP, 2, pixels topY decreases per frame_tick while rising
- FALL_STEP, 2, pixels topY increases per frame_tick while falling unsliced
- SLICE_STEP, 3, pixels topY increases per frame_tick after slice
- APEX_Y, 3, topY value where rise stops
- BOTTOM_Y, 63, launch/despawn topY (sprite almost fully off-screen)
- APEX_HOLD, 8, frame_ticks spent at apex
- X_STEP, 1, pixels leftX increases per frame_tick in RISE/FALL/SLICED
- X_MAX, 40, leftX clamp (96 - 56 sprite width)
- RELAUNCH_GAP, 16, frame_ticks idle before auto relaunch (optional feature only)

Ports:
- CLOCK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per display frame
- start  in  1  launch request pulse
- start_x  in  7  initial leftX, sampled with start
- slice_req  in  1  slash-hit pulse from slash detection
- leftX_watermelon  out  7  sprite anchor X
- topY_watermelon  out  6  sprite anchor Y
- sliced  out  1  1 = route sliced renderer, 0 = whole renderer
- visible  out  1  1 = sprite drawn, 0 = renderer output replaced by BACKGROUND
- busy  out  1  1 in any state other than IDLE
- score_pulse  out  1  one-cycle pulse, sliced melon despawned
- miss_pulse  out  1  one-cycle pulse, unsliced melon despawned

Behaviour:
- Interface: one clock, CLOCK; reset RESET is synchronous and active-high.
- Reset values: state = IDLE, leftX = 0, topY = BOTTOM_Y, sliced = 0, visible = 0, busy = 0, pulses = 0, hold counter = 0. Reset mid-flight aborts immediately and emits no pulse.
- All outputs are registered; effects appear the clock after the triggering input.
- States: IDLE, RISE, HOLD, FALL, SLICED.
- IDLE:
  - On start: leftX = min(start_x, X_MAX), topY = BOTTOM_Y, sliced = 0, visible = 1, go to RISE.
  - start is ignored in every other state.
- RISE, per frame_tick:
  - topY = max(topY - RISE_STEP, APEX_Y), computed 7-bit signed, no wrap.
  - leftX = min(leftX + X_STEP, X_MAX).
  - If the new topY equals APEX_Y: load hold counter with APEX_HOLD, go to HOLD.
- HOLD, per frame_tick:
  - Decrement hold counter; position frozen.
  - When the counter reaches 0, go to FALL (exactly APEX_HOLD ticks in HOLD).
- FALL, per frame_tick:
  - topY = min(topY + FALL_STEP, BOTTOM_Y), computed 7-bit.
  - leftX advances as in RISE.
  - If the new topY equals BOTTOM_Y: miss_pulse for 1 cycle, visible = 0, go to IDLE.
- slice_req in RISE, HOLD or FALL: go to SLICED, sliced = 1.
  - If frame_tick coincides, that tick applies the SLICED move in the same update.
- slice_req is ignored in IDLE and SLICED.
- SLICED, per frame_tick:
  - topY = min(topY + SLICE_STEP, BOTTOM_Y); leftX advances.
  - On reaching BOTTOM_Y: score_pulse for 1 cycle, visible = 0, sliced = 0, go to IDLE.
- X_MAX clamp holds in every state. leftX never exceeds X_MAX; topY stays within [APEX_Y, BOTTOM_Y].
- No frame_tick means no movement; state changes only via slice_req or reset.

Optional Feature:
- Macro: WMELON_AUTO_RELAUNCH_EN.
- Defined:
  - IDLE counts frame_ticks after each despawn.
  - After RELAUNCH_GAP ticks, the block launches exactly as on start, using the current start_x.
  - A manual start during the gap launches immediately and clears the count.
  - The count also clears on RESET.
  - The first launch after RESET still requires start.
- Undefined: IDLE waits indefinitely for start; no gap counter is synthesized.

Test Plan:
- Reset, then start with start_x=10, no slice -> 30 ticks in RISE (topY 63→3, leftX clamps at 40); 8 ticks in HOLD (topY=3); 30 ticks in FALL (topY→63); miss_pulse high exactly 1 cycle; visible=0; busy=0.
- Launch, slice_req after 5 ticks (topY=53) -> sliced=1 next cycle; topY then 56, 59, 62, 63; score_pulse 1 cycle; sliced returns 0.
- slice_req and frame_tick in the same cycle during HOLD (topY=3) -> next cycle topY=6, sliced=1, state SLICED.
- start_x=90 -> leftX=40. start asserted during RISE -> ignored. slice_req in IDLE -> no output change.
- RESET asserted in FALL at topY=31 -> next cycle all reset values; no miss_pulse or score_pulse.
- With WMELON_AUTO_RELAUNCH_EN: after miss_pulse, exactly 16 frame_ticks in IDLE, then visible=1, topY=63, leftX=min(start_x,40). Without the macro, the block stays IDLE after 100 ticks.
